// File: rtl/bibp_pkg.sv
// Shared opcodes and FSM state encoding for the sequential ALU; independent of operand width.
package bibp_pkg;

    localparam logic [2:0] TOPLA = 3'b000;
    localparam logic [2:0] CIKAR = 3'b001;
    localparam logic [2:0] VE    = 3'b010;
    localparam logic [2:0] VEYA  = 3'b011;
    localparam logic [2:0] XOR   = 3'b100;
    localparam logic [2:0] CARP  = 3'b101;

    typedef enum logic [1:0] {
        BOS   = 2'd0,
        HESAP = 2'd1,
        CIKIS = 2'd2
    } durum_t;

endpackage

// File: rtl/bibp_ardisik_if.sv
// Instruction/result handshake bundle; slave is the ALU side, master the sequencer/consumer side.
interface bibp_ardisik_if #(
    parameter int W = 4
);
    logic [2*W+2:0] buyruk;
    logic           buyruk_gecerli;
    logic           buyruk_hazir;
    logic [2*W-1:0] sonuc;
    logic           tasma;
    logic           sifir;
    logic           sonuc_gecerli;
    logic           sonuc_hazir;

    modport slave (
        input  buyruk, buyruk_gecerli, sonuc_hazir,
        output buyruk_hazir, sonuc, tasma, sifir, sonuc_gecerli
    );

    modport master (
        output buyruk, buyruk_gecerli, sonuc_hazir,
        input  buyruk_hazir, sonuc, tasma, sifir, sonuc_gecerli
    );
endinterface

// File: rtl/bibp_carpici.sv
// Shift-add unsigned multiplier, one bit of b per cycle LSB first; W cycles after basla, product valid with bitti.
// Present only when BIBP_ARDISIK_CARPMA_EN is defined; no backpressure, the caller latches carpim on bitti.
`ifdef BIBP_ARDISIK_CARPMA_EN
module bibp_carpici #(
    parameter int W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           basla,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           mesgul,
    output logic           bitti,
    output logic [2*W-1:0] carpim
);
    localparam int SW = $clog2(W);

    logic [2*W-1:0] a_r;
    logic [2*W-1:0] acc;
    logic [2*W-1:0] kismi;
    logic [W-1:0]   b_r;
    logic [SW-1:0]  sayac;

    // The final partial product is folded in combinationally so the caller can register it on bitti.
    assign kismi  = b_r[sayac] ? (a_r << sayac) : '0;
    assign carpim = acc + kismi;
    assign bitti  = mesgul && (sayac == SW'(W - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            acc    <= '0;
            sayac  <= '0;
            mesgul <= 1'b0;
        end else if (basla) begin
            a_r    <= {{W{1'b0}}, a};
            b_r    <= b;
            acc    <= '0;
            sayac  <= '0;
            mesgul <= 1'b1;
        end else if (mesgul) begin
            acc <= carpim;
            if (bitti) begin
                mesgul <= 1'b0;
                sayac  <= '0;
            end else begin
                sayac <= sayac + 1'b1;
            end
        end
    end
endmodule
`endif

// File: rtl/bibp_ardisik.sv
// Sequential ALU: valid/ready instructions in, registered result with carry/zero out; latency 1, multiply W+1 (BIBP_ARDISIK_CARPMA_EN).
// Result held stable while the consumer stalls; buyruk_hazir follows sonuc_hazir combinationally only in CIKIS.
module bibp_ardisik
    import bibp_pkg::*;
#(
    parameter int VERI_GEN = 4
) (
    input logic           clk,
    input logic           rst,
    bibp_ardisik_if.slave bus
);
    localparam int W = VERI_GEN;

    durum_t         durum;
    durum_t         durum_sonraki;
    logic [2:0]     op;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           hazir;
    logic           kabul;
    logic           carp_op;
    logic [W:0]     toplam;
    logic [W:0]     fark;
    logic [2*W-1:0] tek_sonuc;
    logic           tek_tasma;
    logic [2*W-1:0] sonuc_r;
    logic           tasma_r;
    logic           sifir_r;

    assign op = bus.buyruk[2*W+2:2*W];
    assign a  = bus.buyruk[2*W-1:W];
    assign b  = bus.buyruk[W-1:0];

`ifdef BIBP_ARDISIK_CARPMA_EN
    logic           mesgul;
    logic           bitti;
    logic [2*W-1:0] carpim;

    assign carp_op = (op == CARP);

    bibp_carpici #(.W(W)) u_carpici (
        .clk    (clk),
        .rst    (rst),
        .basla  (kabul && carp_op),
        .a      (a),
        .b      (b),
        .mesgul (mesgul),
        .bitti  (bitti),
        .carpim (carpim)
    );

    assign hazir = (durum == BOS && !mesgul) || (durum == CIKIS && bus.sonuc_hazir);
`else
    assign carp_op = 1'b0;
    assign hazir   = (durum == BOS) || (durum == CIKIS && bus.sonuc_hazir);
`endif

    assign kabul = bus.buyruk_gecerli && hazir;

    // Sub at W+1 bits leaves the borrow in bit W, i.e. the two's-complement pattern.
    always_comb begin
        toplam    = {1'b0, a} + {1'b0, b};
        fark      = {1'b0, a} - {1'b0, b};
        tek_sonuc = '0;
        tek_tasma = 1'b0;
        case (op)
            CIKAR: begin
                tek_sonuc = {{(W-1){1'b0}}, fark};
                tek_tasma = fark[W];
            end
            VE:    tek_sonuc = {{W{1'b0}}, a & b};
            VEYA:  tek_sonuc = {{W{1'b0}}, a | b};
            XOR:   tek_sonuc = {{W{1'b0}}, a ^ b};
            TOPLA, CARP: begin
                tek_sonuc = {{(W-1){1'b0}}, toplam};
                tek_tasma = toplam[W];
            end
            default: begin
                tek_sonuc = {{(W-1){1'b0}}, toplam};
                tek_tasma = toplam[W];
            end
        endcase
    end

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOS: begin
                if (kabul) durum_sonraki = carp_op ? HESAP : CIKIS;
            end
            HESAP: begin
`ifdef BIBP_ARDISIK_CARPMA_EN
                if (bitti) durum_sonraki = CIKIS;
`else
                durum_sonraki = BOS;
`endif
            end
            CIKIS: begin
                if (bus.sonuc_hazir) begin
                    if (kabul) durum_sonraki = carp_op ? HESAP : CIKIS;
                    else       durum_sonraki = BOS;
                end
            end
            default: durum_sonraki = BOS;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) durum <= BOS;
        else     durum <= durum_sonraki;
    end

    // Zero flag is registered alongside the result it describes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sonuc_r <= '0;
            tasma_r <= 1'b0;
            sifir_r <= 1'b0;
        end else if (kabul && !carp_op) begin
            sonuc_r <= tek_sonuc;
            tasma_r <= tek_tasma;
            sifir_r <= (tek_sonuc == '0);
`ifdef BIBP_ARDISIK_CARPMA_EN
        end else if (durum == HESAP && bitti) begin
            sonuc_r <= carpim;
            tasma_r <= 1'b0;
            sifir_r <= (carpim == '0);
`endif
        end
    end

    assign bus.buyruk_hazir  = hazir;
    assign bus.sonuc         = sonuc_r;
    assign bus.tasma         = tasma_r;
    assign bus.sifir         = sifir_r;
    assign bus.sonuc_gecerli = (durum == CIKIS);
endmodule

// File: tb/tb_bibp_ardisik.sv
// Scoreboard bench for bibp_ardisik at W=4: expected results queued at accept, compared on result transfer.
module tb_bibp_ardisik;
    import bibp_pkg::*;

    localparam int W = 4;
`ifdef BIBP_ARDISIK_CARPMA_EN
    localparam bit CARPMA = 1'b1;
`else
    localparam bit CARPMA = 1'b0;
`endif

    typedef struct {
        logic [2*W-1:0] sonuc;
        logic           tasma;
        logic           sifir;
    } beklenen_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   kontrol_sayisi = 0;
    int   hata_sayisi = 0;
    beklenen_t kuyruk[$];
    beklenen_t e;

    bibp_ardisik_if #(.W(W)) bus();

    bibp_ardisik #(.VERI_GEN(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen, input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", etiket, gozlenen, beklenen);
        end
    endtask

    function automatic beklenen_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        beklenen_t   m;
        int unsigned ai;
        int unsigned bi;
        int unsigned r;
        logic        t;
        ai = a;
        bi = b;
        t  = 1'b0;
        case (op)
            3'b001: begin
                r = (ai - bi) & ((1 << (W + 1)) - 1);
                t = (ai < bi);
            end
            3'b010: r = ai & bi;
            3'b011: r = ai | bi;
            3'b100: r = ai ^ bi;
`ifdef BIBP_ARDISIK_CARPMA_EN
            3'b101: r = ai * bi;
`endif
            default: begin
                r = ai + bi;
                t = r[W];
            end
        endcase
        m.sonuc = r[2*W-1:0];
        m.tasma = t;
        m.sifir = (r == 0);
        return m;
    endfunction

    // Called in the phase just after a rising edge; returns just after the accepting edge.
    task automatic gonder(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bit alindi;
        int n;
        alindi = 1'b0;
        n = 0;
        bus.buyruk = {op, a, b};
        bus.buyruk_gecerli = 1'b1;
        while (!alindi && n < 50) begin
            @(negedge clk);
            n++;
            if (bus.buyruk_hazir) alindi = 1'b1;
        end
        if (!alindi) kontrol("hazir_zaman", 32'd0, 32'd1);
        else kuyruk.push_back(model(op, a, b));
        @(posedge clk);
        #1;
        bus.buyruk_gecerli = 1'b0;
        bus.buyruk = '1;
    endtask

    task automatic gecikme(input string etiket, input int bek);
        bit gorundu;
        int n;
        gorundu = 1'b0;
        n = 0;
        while (!gorundu && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.sonuc_gecerli) gorundu = 1'b1;
            else kontrol("hesap_hazir", bus.buyruk_hazir, 1'b0);
        end
        kontrol(etiket, n, bek);
    endtask

    task automatic adim();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && bus.sonuc_gecerli && bus.sonuc_hazir) begin
            if (kuyruk.size() == 0) begin
                kontrol("fazla_sonuc", 32'd1, 32'd0);
            end else begin
                e = kuyruk.pop_front();
                kontrol("sb_sonuc", bus.sonuc, e.sonuc);
                kontrol("sb_tasma", bus.tasma, e.tasma);
                kontrol("sb_sifir", bus.sifir, e.sifir);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bas;
        int n;
        rst = 1'b1;
        bus.buyruk = '0;
        bus.buyruk_gecerli = 1'b0;
        bus.sonuc_hazir = 1'b0;
        #12;
        kontrol("rst_sonuc",   bus.sonuc, 8'h00);
        kontrol("rst_tasma",   bus.tasma, 1'b0);
        kontrol("rst_sifir",   bus.sifir, 1'b0);
        kontrol("rst_gecerli", bus.sonuc_gecerli, 1'b0);
        kontrol("rst_hazir",   bus.buyruk_hazir, 1'b1);
        adim();
        rst = 1'b0;
        bus.sonuc_hazir = 1'b1;
        adim();

        gonder(TOPLA, 4'd9, 4'd8);
        gecikme("lat_topla", 1);
        kontrol("topla_sonuc", bus.sonuc, 8'h11);
        kontrol("topla_tasma", bus.tasma, 1'b1);
        kontrol("topla_sifir", bus.sifir, 1'b0);
        adim();

        gonder(CIKAR, 4'd3, 4'd5);
        gecikme("lat_cikar", 1);
        kontrol("cikar_borc_sonuc", bus.sonuc, 8'h1E);
        kontrol("cikar_borc_tasma", bus.tasma, 1'b1);
        adim();
        gonder(CIKAR, 4'd5, 4'd3);
        gecikme("lat_cikar2", 1);
        kontrol("cikar_sonuc", bus.sonuc, 8'h02);
        kontrol("cikar_tasma", bus.tasma, 1'b0);
        adim();

        gonder(XOR, 4'hA, 4'hA);
        gecikme("lat_xor", 1);
        kontrol("xor_sonuc", bus.sonuc, 8'h00);
        kontrol("xor_sifir", bus.sifir, 1'b1);
        kontrol("xor_tasma", bus.tasma, 1'b0);
        adim();

        // Back-to-back single-cycle ops: one accept per clock.
        bas = cyc;
        for (int i = 0; i < 6; i++)
            gonder(3'($urandom_range(0, 4)), W'($urandom), W'($urandom));
        kontrol("verim", cyc - bas, 6);

        for (int i = 0; i < 10; i++)
            gonder(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
        n = 0;
        while (kuyruk.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        kontrol("kuyruk_bos1", kuyruk.size(), 0);
        adim();

        gonder(CARP, 4'd15, 4'd15);
        gecikme("lat_carp", CARPMA ? W + 1 : 1);
        kontrol("carp_sonuc", bus.sonuc, CARPMA ? 8'hE1 : 8'h1E);
        kontrol("carp_tasma", bus.tasma, CARPMA ? 1'b0 : 1'b1);
        adim();

        bus.sonuc_hazir = 1'b0;
        gonder(TOPLA, 4'd7, 4'd6);
        gecikme("lat_bp", 1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            kontrol("bp_sonuc",   bus.sonuc, 8'h0D);
            kontrol("bp_tasma",   bus.tasma, 1'b0);
            kontrol("bp_gecerli", bus.sonuc_gecerli, 1'b1);
            kontrol("bp_hazir",   bus.buyruk_hazir, 1'b0);
        end
        adim();
        bus.sonuc_hazir = 1'b1;
        gonder(VEYA, 4'h5, 4'h2);
        gecikme("lat_veya", 1);
        kontrol("veya_sonuc", bus.sonuc, 8'h07);
        adim();

        // Reset one cycle after accept: second HESAP cycle with multiply, a held result otherwise.
        bus.sonuc_hazir = 1'b0;
        gonder(CARP, 4'd15, 4'd15);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        kontrol("arst_gecerli", bus.sonuc_gecerli, 1'b0);
        kontrol("arst_sonuc",   bus.sonuc, 8'h00);
        kontrol("arst_hazir",   bus.buyruk_hazir, 1'b1);
        kuyruk.delete();
        adim();
        rst = 1'b0;
        bus.sonuc_hazir = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            kontrol("arst_sonra_gecerli", bus.sonuc_gecerli, 1'b0);
        end
        adim();

        gonder(TOPLA, 4'd0, 4'd0);
        gecikme("lat_son", 1);
        kontrol("son_sifir", bus.sifir, 1'b1);
        adim();
        n = 0;
        while (kuyruk.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        kontrol("kuyruk_bos2", kuyruk.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end
endmodule
